// File: rtl/calc_pkg.sv
// Shared types and defaults for the calculator sequencer.
//   op_t    : arithmetic operation code sent to the external arithmetic unit
//   state_t : sequencer states
//   is_bcd  : true for keypad digit codes 0-9
package calc_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_MUL = 2'd2,
    OP_RSV = 2'd3
  } op_t;

  typedef enum logic [2:0] {
    ENTRY_A,
    ENTRY_B,
    ISSUE,
    WAIT,
    RESULT,
    ERROR
  } state_t;

  localparam int WIDTH_DEF      = 16;
  localparam int MAX_DIGITS_DEF = 5;
  localparam int TIMEOUT_DEF    = 64;

  function automatic logic is_bcd(input logic [3:0] d);
    return d <= 4'd9;
  endfunction

endpackage

// File: rtl/calc_digit_acc.sv
// Decimal operand accumulator: keeps magnitude, digit count and sign of one
// operand and builds it from keypad digits with a x10 shift-add.
// Ports:
//   clk, nRST      clock, asynchronous active-low reset
//   clr            zero magnitude, count and sign (highest priority)
//   load_en/val    load a signed value (result chaining)
//   neg_toggle     flip the sign
//   digit_en/digit append a digit if it fits
//   fresh          treat the current operand as empty for this digit
//   value          current signed operand
//   value_nxt      signed operand as it will be after this cycle
//   accept         the offered digit is being taken this cycle
module calc_digit_acc
  import calc_pkg::*;
#(
  parameter int WIDTH      = WIDTH_DEF,
  parameter int MAX_DIGITS = MAX_DIGITS_DEF
) (
  input  logic                    clk,
  input  logic                    nRST,
  input  logic                    clr,
  input  logic                    load_en,
  input  logic signed [WIDTH-1:0] load_val,
  input  logic                    neg_toggle,
  input  logic                    digit_en,
  input  logic                    fresh,
  input  logic [3:0]              digit,
  output logic signed [WIDTH-1:0] value,
  output logic signed [WIDTH-1:0] value_nxt,
  output logic                    accept
);

  localparam int CW = $clog2(MAX_DIGITS + 1);
  // Largest positive magnitude, widened so mag*10+digit cannot wrap.
  localparam logic [WIDTH+3:0] MAX_POS = {5'b0, {(WIDTH-1){1'b1}}};

  logic [WIDTH-1:0] mag, mag_n, base_mag;
  logic [CW-1:0]    cnt, cnt_n, base_cnt;
  logic             neg_f, neg_n;
  logic [WIDTH+3:0] mag_x10;

  assign base_mag = fresh ? '0 : mag;
  assign base_cnt = fresh ? '0 : cnt;

  // mag*10 + digit as (mag<<3) + (mag<<1) + digit
  assign mag_x10 = ({4'b0, base_mag} << 3) + ({4'b0, base_mag} << 1)
                 + {{WIDTH{1'b0}}, digit};

  assign accept = digit_en && is_bcd(digit) && (base_cnt < CW'(MAX_DIGITS))
               && (mag_x10 <= MAX_POS);

  always_comb begin
    mag_n = mag;
    cnt_n = cnt;
    neg_n = neg_f;
    if (clr) begin
      mag_n = '0;
      cnt_n = '0;
      neg_n = 1'b0;
    end else if (load_en) begin
      // A loaded result is stored as sign + magnitude; the most negative value
      // still fits because mag is WIDTH bits unsigned.
      neg_n = load_val[WIDTH-1];
      mag_n = load_val[WIDTH-1] ? $unsigned(-load_val) : $unsigned(load_val);
      cnt_n = '0;
    end else if (neg_toggle) begin
      neg_n = ~neg_f;
    end else if (accept) begin
      mag_n = mag_x10[WIDTH-1:0];
      cnt_n = base_cnt + CW'(1);
      if (fresh) neg_n = 1'b0;
    end
  end

  assign value     = neg_f ? -$signed(mag) : $signed(mag);
  assign value_nxt = neg_n ? -$signed(mag_n) : $signed(mag_n);

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      mag   <= '0;
      cnt   <= '0;
      neg_f <= 1'b0;
    end else begin
      mag   <= mag_n;
      cnt   <= cnt_n;
      neg_f <= neg_n;
    end
  end

endmodule

// File: rtl/calc_ctrl.sv
// Signed calculator sequencer: collects two decimal operands from a keypad,
// issues ADD/SUB/MUL to an external arithmetic unit over start/done, shows
// entry and result, supports chaining, clear, overflow and a done watchdog.
// Ports:
//   clk, nRST                 clock, asynchronous active-low reset
//   digit_valid/digit         keypad digit strobe (BCD, 10-15 ignored)
//   op_valid/op               operation strobe (op_t, OP_RSV ignored)
//   neg, equal, clear         sign toggle / evaluate / abort strobes
//   alu_start/op/a/b          request to the arithmetic unit (held until done)
//   alu_done/result/ovf       completion from the arithmetic unit
//   display                   signed value shown to the user
//   complete/error/busy       RESULT / ERROR / ISSUE-or-WAIT indicators
module calc_ctrl
  import calc_pkg::*;
#(
  parameter int WIDTH      = WIDTH_DEF,
  parameter int MAX_DIGITS = MAX_DIGITS_DEF,
  parameter int TIMEOUT    = TIMEOUT_DEF
) (
  input  logic                    clk,
  input  logic                    nRST,
  input  logic                    digit_valid,
  input  logic [3:0]              digit,
  input  logic                    op_valid,
  input  logic [1:0]              op,
  input  logic                    neg,
  input  logic                    equal,
  input  logic                    clear,
  output logic                    alu_start,
  output logic [1:0]              alu_op,
  output logic signed [WIDTH-1:0] alu_a,
  output logic signed [WIDTH-1:0] alu_b,
  input  logic                    alu_done,
  input  logic signed [WIDTH-1:0] alu_result,
  input  logic                    alu_ovf,
  output logic signed [WIDTH-1:0] display,
  output logic                    complete,
  output logic                    error,
  output logic                    busy
);

  localparam int TW = $clog2(TIMEOUT + 1);

  state_t        state;
  op_t           op_q;
  logic [TW-1:0] wait_cnt;

  // Strobe priority: clear > equal > op_valid > neg > digit_valid
  logic ev_clear, ev_equal, ev_op, ev_neg, ev_digit, op_ok;

  assign ev_clear = clear;
  assign ev_equal = !clear && equal;
  assign ev_op    = !clear && !equal && op_valid;
  assign ev_neg   = !clear && !equal && !op_valid && neg;
  assign ev_digit = !clear && !equal && !op_valid && !neg && digit_valid;
  assign op_ok    = ev_op && (op_t'(op) != OP_RSV);

  logic a_load, a_neg, a_dig, a_fresh, b_clr, b_neg, b_dig;
  logic signed [WIDTH-1:0] a_val, a_nxt, b_val, b_nxt;
  logic a_accept, b_accept;

  always_comb begin
    a_load  = (state == WAIT) && alu_done && !alu_ovf;
    a_neg   = (state == ENTRY_A) && ev_neg;
    a_dig   = ((state == ENTRY_A) || (state == RESULT)) && ev_digit;
    a_fresh = (state == RESULT);
    b_clr   = ev_clear || (((state == ENTRY_A) || (state == RESULT)) && op_ok);
    b_neg   = (state == ENTRY_B) && ev_neg;
    b_dig   = (state == ENTRY_B) && ev_digit;
  end

  calc_digit_acc #(.WIDTH(WIDTH), .MAX_DIGITS(MAX_DIGITS)) u_acc_a (
    .clk(clk), .nRST(nRST), .clr(ev_clear), .load_en(a_load), .load_val(alu_result),
    .neg_toggle(a_neg), .digit_en(a_dig), .fresh(a_fresh), .digit(digit),
    .value(a_val), .value_nxt(a_nxt), .accept(a_accept)
  );

  calc_digit_acc #(.WIDTH(WIDTH), .MAX_DIGITS(MAX_DIGITS)) u_acc_b (
    .clk(clk), .nRST(nRST), .clr(b_clr), .load_en(1'b0), .load_val('0),
    .neg_toggle(b_neg), .digit_en(b_dig), .fresh(1'b0), .digit(digit),
    .value(b_val), .value_nxt(b_nxt), .accept(b_accept)
  );

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state     <= ENTRY_A;
      op_q      <= OP_ADD;
      wait_cnt  <= '0;
      alu_start <= 1'b0;
      alu_op    <= '0;
      alu_a     <= '0;
      alu_b     <= '0;
      display   <= '0;
      complete  <= 1'b0;
      error     <= 1'b0;
      busy      <= 1'b0;
    end else begin
      alu_start <= 1'b0;
      if (ev_clear) begin
        state    <= ENTRY_A;
        op_q     <= OP_ADD;
        alu_op   <= '0;
        alu_a    <= '0;
        alu_b    <= '0;
        display  <= '0;
        complete <= 1'b0;
        error    <= 1'b0;
        busy     <= 1'b0;
      end else begin
        case (state)
          ENTRY_A: begin
            display <= a_nxt;
            if (op_ok) begin
              op_q  <= op_t'(op);
              state <= ENTRY_B;
            end
          end
          ENTRY_B: begin
            display <= b_nxt;
            if (ev_equal) begin
              alu_start <= 1'b1;
              alu_a     <= a_val;
              alu_b     <= b_val;
              alu_op    <= op_q;
              busy      <= 1'b1;
              state     <= ISSUE;
            end else if (op_ok) begin
              op_q <= op_t'(op);
            end
          end
          ISSUE: begin
            wait_cnt <= '0;
            state    <= WAIT;
          end
          WAIT: begin
            if (alu_done) begin
              busy <= 1'b0;
              if (alu_ovf) begin
                error   <= 1'b1;
                display <= '0;
                state   <= ERROR;
              end else begin
                complete <= 1'b1;
                display  <= alu_result;
                state    <= RESULT;
              end
            end else if (wait_cnt == TW'(TIMEOUT - 1)) begin
              busy    <= 1'b0;
              error   <= 1'b1;
              display <= '0;
              state   <= ERROR;
            end else begin
              wait_cnt <= wait_cnt + TW'(1);
            end
          end
          RESULT: begin
            // Operand A already holds the result, so equal re-runs last op/B on it.
            if (ev_equal) begin
              alu_start <= 1'b1;
              alu_a     <= a_val;
              alu_b     <= b_val;
              alu_op    <= op_q;
              busy      <= 1'b1;
              complete  <= 1'b0;
              state     <= ISSUE;
            end else if (op_ok) begin
              op_q     <= op_t'(op);
              complete <= 1'b0;
              display  <= '0;
              state    <= ENTRY_B;
            end else if (a_accept) begin
              complete <= 1'b0;
              display  <= a_nxt;
              state    <= ENTRY_A;
            end
          end
          ERROR: begin
            display <= '0;
          end
          default: state <= ENTRY_A;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_calc_ctrl.sv
module tb_calc_ctrl;

  logic clk = 1'b0;
  logic nRST = 1'b0;
  logic digit_valid = 1'b0;
  logic [3:0] digit = '0;
  logic op_valid = 1'b0;
  logic [1:0] op = '0;
  logic neg = 1'b0;
  logic equal = 1'b0;
  logic clear = 1'b0;
  logic alu_start;
  logic [1:0] alu_op;
  logic signed [15:0] alu_a, alu_b;
  logic alu_done = 1'b0;
  logic signed [15:0] alu_result = '0;
  logic alu_ovf = 1'b0;
  logic signed [15:0] display;
  logic complete, error, busy;

  int tests = 0;
  int fails = 0;

  calc_ctrl #(.WIDTH(16), .MAX_DIGITS(5), .TIMEOUT(64)) dut (
    .clk(clk), .nRST(nRST), .digit_valid(digit_valid), .digit(digit),
    .op_valid(op_valid), .op(op), .neg(neg), .equal(equal), .clear(clear),
    .alu_start(alu_start), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .alu_done(alu_done), .alu_result(alu_result), .alu_ovf(alu_ovf),
    .display(display), .complete(complete), .error(error), .busy(busy)
  );

  always #5 clk = ~clk;

  // Stimulus drivers: assert a strobe for one cycle, return on the next falling edge.
  task automatic press_digit(input logic [3:0] d);
    @(negedge clk); digit_valid = 1'b1; digit = d;
    @(negedge clk); digit_valid = 1'b0;
  endtask

  task automatic press_op(input logic [1:0] o);
    @(negedge clk); op_valid = 1'b1; op = o;
    @(negedge clk); op_valid = 1'b0;
  endtask

  task automatic press_neg();
    @(negedge clk); neg = 1'b1;
    @(negedge clk); neg = 1'b0;
  endtask

  task automatic press_equal();
    @(negedge clk); equal = 1'b1;
    @(negedge clk); equal = 1'b0;
  endtask

  task automatic press_clear();
    @(negedge clk); clear = 1'b1;
    @(negedge clk); clear = 1'b0;
  endtask

  // Called while the DUT is in ISSUE: done lands in the following WAIT cycle.
  task automatic alu_respond(input logic signed [15:0] r, input logic v);
    @(negedge clk); alu_done = 1'b1; alu_result = r; alu_ovf = v;
    @(negedge clk); alu_done = 1'b0; alu_ovf = 1'b0;
  endtask

  task automatic test_reset();
    nRST = 1'b0;
    repeat (2) @(negedge clk);
    tests++; if (alu_start !== 1'b0) begin fails++; $display("FAIL reset_alu_start got %0b want 0", alu_start); end
    tests++; if (display !== 16'sd0) begin fails++; $display("FAIL reset_display got %0d want 0", display); end
    tests++; if ({complete, error, busy} !== 3'b000) begin fails++; $display("FAIL reset_flags got %b want 000", {complete, error, busy}); end
    tests++; if (alu_a !== 16'sd0 || alu_b !== 16'sd0 || alu_op !== 2'd0) begin fails++; $display("FAIL reset_alu_bus got a=%0d b=%0d op=%0d want 0", alu_a, alu_b, alu_op); end
    nRST = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_add();
    press_digit(4'd1); press_digit(4'd2);
    tests++; if (display !== 16'sd12) begin fails++; $display("FAIL add_entry_a got %0d want 12", display); end
    press_op(2'd0);
    press_digit(4'd3); press_digit(4'd4);
    tests++; if (display !== 16'sd34) begin fails++; $display("FAIL add_entry_b got %0d want 34", display); end
    press_equal();
    tests++; if (alu_start !== 1'b1) begin fails++; $display("FAIL add_start got %0b want 1", alu_start); end
    tests++; if (alu_a !== 16'sd12 || alu_b !== 16'sd34 || alu_op !== 2'd0) begin fails++; $display("FAIL add_operands got a=%0d b=%0d op=%0d want 12 34 0", alu_a, alu_b, alu_op); end
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL add_busy got %0b want 1", busy); end
    alu_respond(16'sd46, 1'b0);
    tests++; if (display !== 16'sd46 || complete !== 1'b1) begin fails++; $display("FAIL add_result got disp=%0d cpl=%0b want 46 1", display, complete); end
    tests++; if (busy !== 1'b0 || alu_start !== 1'b0) begin fails++; $display("FAIL add_idle got busy=%0b start=%0b want 0 0", busy, alu_start); end
  endtask

  task automatic test_range();
    press_clear();
    press_digit(4'd3); press_digit(4'd2); press_digit(4'd7); press_digit(4'd6); press_digit(4'd7);
    tests++; if (display !== 16'sd32767) begin fails++; $display("FAIL range_max got %0d want 32767", display); end
    press_digit(4'd9);
    tests++; if (display !== 16'sd32767) begin fails++; $display("FAIL range_sixth_digit got %0d want 32767", display); end
    press_clear();
    tests++; if (display !== 16'sd0) begin fails++; $display("FAIL range_clear got %0d want 0", display); end
    press_digit(4'd3); press_digit(4'd2); press_digit(4'd7); press_digit(4'd6); press_digit(4'd8);
    tests++; if (display !== 16'sd3276) begin fails++; $display("FAIL range_overrange got %0d want 3276", display); end
    press_digit(4'd11);
    tests++; if (display !== 16'sd3276) begin fails++; $display("FAIL range_non_bcd got %0d want 3276", display); end
  endtask

  task automatic test_neg_chain();
    press_clear();
    press_neg(); press_digit(4'd5);
    tests++; if (display !== -16'sd5) begin fails++; $display("FAIL neg_entry got %0d want -5", display); end
    press_op(2'd2); press_digit(4'd7); press_equal();
    tests++; if (alu_a !== -16'sd5 || alu_b !== 16'sd7 || alu_op !== 2'd2) begin fails++; $display("FAIL neg_mul_operands got a=%0d b=%0d op=%0d want -5 7 2", alu_a, alu_b, alu_op); end
    alu_respond(-16'sd35, 1'b0);
    tests++; if (display !== -16'sd35 || complete !== 1'b1) begin fails++; $display("FAIL neg_mul_result got disp=%0d cpl=%0b want -35 1", display, complete); end
    press_op(2'd1);
    tests++; if (complete !== 1'b0) begin fails++; $display("FAIL chain_leave_result got cpl=%0b want 0", complete); end
    press_digit(4'd5); press_equal();
    tests++; if (alu_a !== -16'sd35 || alu_b !== 16'sd5 || alu_op !== 2'd1) begin fails++; $display("FAIL chain_operands got a=%0d b=%0d op=%0d want -35 5 1", alu_a, alu_b, alu_op); end
    alu_respond(-16'sd40, 1'b0);
    press_equal();
    tests++; if (alu_start !== 1'b1 || alu_a !== -16'sd40 || alu_b !== 16'sd5 || alu_op !== 2'd1) begin fails++; $display("FAIL repeat_equal got start=%0b a=%0d b=%0d op=%0d want 1 -40 5 1", alu_start, alu_a, alu_b, alu_op); end
    alu_respond(-16'sd45, 1'b0);
    tests++; if (display !== -16'sd45) begin fails++; $display("FAIL repeat_result got %0d want -45", display); end
  endtask

  task automatic test_overflow();
    press_clear();
    press_digit(4'd9); press_op(2'd0); press_digit(4'd9); press_equal();
    alu_respond(16'sd18, 1'b1);
    tests++; if (error !== 1'b1 || display !== 16'sd0 || complete !== 1'b0) begin fails++; $display("FAIL ovf_error got err=%0b disp=%0d cpl=%0b want 1 0 0", error, display, complete); end
    press_digit(4'd3);
    tests++; if (error !== 1'b1 || display !== 16'sd0) begin fails++; $display("FAIL ovf_digit_ignored got err=%0b disp=%0d want 1 0", error, display); end
    press_equal();
    tests++; if (alu_start !== 1'b0 || error !== 1'b1) begin fails++; $display("FAIL ovf_equal_ignored got start=%0b err=%0b want 0 1", alu_start, error); end
    press_clear();
    tests++; if (error !== 1'b0) begin fails++; $display("FAIL ovf_clear got err=%0b want 0", error); end
    press_digit(4'd4);
    tests++; if (display !== 16'sd4) begin fails++; $display("FAIL ovf_after_clear got %0d want 4", display); end
  endtask

  task automatic test_timeout();
    press_clear();
    press_digit(4'd1); press_op(2'd0); press_digit(4'd2); press_equal();
    repeat (64) @(negedge clk);
    tests++; if (error !== 1'b0 || busy !== 1'b1) begin fails++; $display("FAIL timeout_early got err=%0b busy=%0b want 0 1", error, busy); end
    @(negedge clk);
    tests++; if (error !== 1'b1 || busy !== 1'b0) begin fails++; $display("FAIL timeout_fire got err=%0b busy=%0b want 1 0", error, busy); end
  endtask

  task automatic test_reset_mid_wait();
    press_clear();
    press_digit(4'd1); press_op(2'd0); press_digit(4'd2); press_equal();
    @(negedge clk);
    tests++; if (busy !== 1'b1 || display !== 16'sd2) begin fails++; $display("FAIL midwait_pre got busy=%0b disp=%0d want 1 2", busy, display); end
    #2 nRST = 1'b0;
    #1;
    tests++; if (busy !== 1'b0 || alu_a !== 16'sd0 || alu_b !== 16'sd0 || display !== 16'sd0) begin fails++; $display("FAIL midwait_async got busy=%0b a=%0d b=%0d disp=%0d want 0 0 0 0", busy, alu_a, alu_b, display); end
    @(negedge clk); nRST = 1'b1;
    @(negedge clk); alu_done = 1'b1; alu_result = 16'sd99;
    @(negedge clk); alu_done = 1'b0;
    tests++; if (complete !== 1'b0 || display !== 16'sd0 || error !== 1'b0) begin fails++; $display("FAIL midwait_late_done got cpl=%0b disp=%0d err=%0b want 0 0 0", complete, display, error); end
    press_digit(4'd7);
    tests++; if (display !== 16'sd7) begin fails++; $display("FAIL midwait_entry_a got %0d want 7", display); end
  endtask

  task automatic test_priority();
    press_clear();
    press_digit(4'd1); press_op(2'd0); press_digit(4'd2);
    @(negedge clk); clear = 1'b1; equal = 1'b1;
    @(negedge clk); clear = 1'b0; equal = 1'b0;
    tests++; if (alu_start !== 1'b0 || busy !== 1'b0 || display !== 16'sd0) begin fails++; $display("FAIL prio_clear_equal got start=%0b busy=%0b disp=%0d want 0 0 0", alu_start, busy, display); end
    press_equal();
    tests++; if (alu_start !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL prio_entry_a_equal got start=%0b busy=%0b want 0 0", alu_start, busy); end
    press_digit(4'd3);
    tests++; if (display !== 16'sd3) begin fails++; $display("FAIL prio_fresh_a got %0d want 3", display); end
    press_op(2'd0); press_digit(4'd4);
    @(negedge clk); equal = 1'b1; op_valid = 1'b1; op = 2'd2;
    @(negedge clk); equal = 1'b0; op_valid = 1'b0;
    tests++; if (alu_start !== 1'b1 || alu_op !== 2'd0 || alu_a !== 16'sd3 || alu_b !== 16'sd4) begin fails++; $display("FAIL prio_equal_op got start=%0b op=%0d a=%0d b=%0d want 1 0 3 4", alu_start, alu_op, alu_a, alu_b); end
    alu_respond(16'sd7, 1'b0);
    tests++; if (display !== 16'sd7 || complete !== 1'b1) begin fails++; $display("FAIL prio_result got disp=%0d cpl=%0b want 7 1", display, complete); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_range();
    test_neg_chain();
    test_overflow();
    test_timeout();
    test_reset_mid_wait();
    test_priority();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
